// File: rtl/rob_pkg.sv
// Shared reorder-buffer sizing, entry/retire types and a dispatch popcount helper.
// Optional build macro recognised by the ROB: ROB_PERF_CNT_EN.
package rob_pkg;
    localparam int ROB_DEPTH     = 32;
    localparam int MACHINE_WIDTH = 3;
    localparam int ISSUE_WIDTH   = 7;
    localparam int PRF_WIDTH     = 7;
    localparam int ARF_WIDTH     = 5;
    localparam int ROB_IDX_WIDTH = $clog2(ROB_DEPTH);
    localparam int ROB_PTR_WIDTH = ROB_IDX_WIDTH + 1;
    localparam int RET_CNT_WIDTH = $clog2(MACHINE_WIDTH + 1);

    typedef struct packed {
        logic                 valid;
        logic                 complete;
        logic                 mispredict;
        logic                 halt;
        logic [ARF_WIDTH-1:0] arn;
        logic [PRF_WIDTH-1:0] prn;
        logic [PRF_WIDTH-1:0] old_prn;
    } ROB_ENTRY;

    typedef struct packed {
        logic                 valid;
        logic [ARF_WIDTH-1:0] arn;
        logic [PRF_WIDTH-1:0] prn;
        logic [PRF_WIDTH-1:0] old_prn;
    } RETIRE_PACKET;

    function automatic logic [ROB_PTR_WIDTH-1:0] popcount_mw(input logic [MACHINE_WIDTH-1:0] v);
        logic [ROB_PTR_WIDTH-1:0] n;
        n = {ROB_PTR_WIDTH{1'b0}};
        for (int i = 0; i < MACHINE_WIDTH; i++) begin
            n = n + ROB_PTR_WIDTH'(v[i]);
        end
        return n;
    endfunction
endpackage

// File: rtl/rob_if.sv
// Dispatch / completion / retire bundle between the pipeline (master) and the ROB (slave).
interface rob_if;
    import rob_pkg::*;

    logic [MACHINE_WIDTH-1:0]                    disp_valid;
    logic [MACHINE_WIDTH-1:0][ARF_WIDTH-1:0]     disp_arn;
    logic [MACHINE_WIDTH-1:0][PRF_WIDTH-1:0]     disp_prn;
    logic [MACHINE_WIDTH-1:0][PRF_WIDTH-1:0]     disp_old_prn;
    logic [MACHINE_WIDTH-1:0]                    disp_halt;
    logic                                        disp_ready;
    logic [MACHINE_WIDTH-1:0][ROB_IDX_WIDTH-1:0] disp_entry;
    logic [ISSUE_WIDTH-1:0]                      cdb_valid;
    logic [ISSUE_WIDTH-1:0][ROB_IDX_WIDTH-1:0]   cdb_rob_entry;
    logic [ISSUE_WIDTH-1:0]                      cdb_mispredict;
    logic [MACHINE_WIDTH-1:0]                    ret_valid;
    logic [MACHINE_WIDTH-1:0][ARF_WIDTH-1:0]     ret_arn;
    logic [MACHINE_WIDTH-1:0][PRF_WIDTH-1:0]     ret_prn;
    logic [MACHINE_WIDTH-1:0][PRF_WIDTH-1:0]     ret_old_prn;
    logic                                        rs_nuke;
    logic                                        rob_halted;
    logic [ROB_PTR_WIDTH-1:0]                    rob_free_cnt;

    modport master (
        output disp_valid, disp_arn, disp_prn, disp_old_prn, disp_halt,
        output cdb_valid, cdb_rob_entry, cdb_mispredict,
        input  disp_ready, disp_entry, ret_valid, ret_arn, ret_prn, ret_old_prn,
        input  rs_nuke, rob_halted, rob_free_cnt
    );

    modport slave (
        input  disp_valid, disp_arn, disp_prn, disp_old_prn, disp_halt,
        input  cdb_valid, cdb_rob_entry, cdb_mispredict,
        output disp_ready, disp_entry, ret_valid, ret_arn, ret_prn, ret_old_prn,
        output rs_nuke, rob_halted, rob_free_cnt
    );
endinterface

// File: rtl/rob_chk.sv
// Protocol checker: a CDB completion must target a live ROB entry.
module rob_chk
    import rob_pkg::*;
(
    input logic                   clk,
    input logic                   rst_n,
    input logic [ISSUE_WIDTH-1:0] i_cdb_bad
);
    a_cdb_targets_valid_entry: assert property (
        @(posedge clk) disable iff (!rst_n) i_cdb_bad == {ISSUE_WIDTH{1'b0}}
    );
endmodule

// File: rtl/rob_retire_sel.sv
// In-order retire selection over the MACHINE_WIDTH entries at the ROB head.
module rob_retire_sel
    import rob_pkg::*;
(
    input  logic [MACHINE_WIDTH-1:0] i_valid,
    input  logic [MACHINE_WIDTH-1:0] i_complete,
    input  logic [MACHINE_WIDTH-1:0] i_mispredict,
    input  logic [MACHINE_WIDTH-1:0] i_halt,
    input  logic                     i_halted,
    output logic [MACHINE_WIDTH-1:0] o_mask,
    output logic [RET_CNT_WIDTH-1:0] o_count,
    output logic                     o_nuke,
    output logic                     o_halt
);
    logic w_scan;

    // Scan oldest-first; a mispredict or halt retires itself but ends the group.
    always_comb begin
        w_scan  = ~i_halted;
        o_mask  = {MACHINE_WIDTH{1'b0}};
        o_count = {RET_CNT_WIDTH{1'b0}};
        o_nuke  = 1'b0;
        o_halt  = 1'b0;
        for (int j = 0; j < MACHINE_WIDTH; j++) begin
            if (w_scan && i_valid[j] && i_complete[j]) begin
                o_mask[j] = 1'b1;
                o_count   = o_count + RET_CNT_WIDTH'(1);
                o_nuke    = o_nuke | i_mispredict[j];
                o_halt    = o_halt | i_halt[j];
                w_scan    = ~(i_mispredict[j] | i_halt[j]);
            end else begin
                w_scan = 1'b0;
            end
        end
    end
endmodule

// File: rtl/rob.sv
// Reorder buffer: in-order dispatch, CDB completion, up to MACHINE_WIDTH in-order retires per cycle.
// Define ROB_PERF_CNT_EN to add the perf_retired / perf_nuke counters.
module rob
    import rob_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    rob_if.slave rob_bus
`ifdef ROB_PERF_CNT_EN
    ,
    output logic [31:0] perf_retired,
    output logic [15:0] perf_nuke
`endif
);
    ROB_ENTRY                 r_rob [ROB_DEPTH];
    RETIRE_PACKET             r_ret [MACHINE_WIDTH];
    logic [ROB_PTR_WIDTH-1:0] r_head, r_tail;
    logic                     r_halted, r_nuke;

    logic [ROB_PTR_WIDTH-1:0] w_count, w_free, w_new_head;
    logic [ROB_IDX_WIDTH-1:0] w_disp_idx [MACHINE_WIDTH];
    logic [ROB_IDX_WIDTH-1:0] w_ret_idx  [MACHINE_WIDTH];
    logic [ROB_IDX_WIDTH-1:0] w_disp_off;
    logic [MACHINE_WIDTH-1:0] w_hv, w_hc, w_hm, w_hh, w_ret_mask;
    logic [RET_CNT_WIDTH-1:0] w_ret_cnt;
    logic                     w_sel_nuke, w_sel_halt, w_disp_ready, w_disp_fire;
    logic [ISSUE_WIDTH-1:0]   w_cdb_bad;

    // Free count deliberately ignores this cycle's retires.
    assign w_count      = r_tail - r_head;
    assign w_free       = ROB_PTR_WIDTH'(ROB_DEPTH) - w_count;
    assign w_disp_ready = (w_free >= ROB_PTR_WIDTH'(MACHINE_WIDTH)) && !r_halted && !r_nuke;
    assign w_disp_fire  = w_disp_ready && !w_sel_nuke;
    assign w_new_head   = r_head + ROB_PTR_WIDTH'(w_ret_cnt);

    // Slot i takes tail plus the number of valid slots before it.
    always_comb begin
        w_disp_off = {ROB_IDX_WIDTH{1'b0}};
        for (int i = 0; i < MACHINE_WIDTH; i++) begin
            w_disp_idx[i] = r_tail[ROB_IDX_WIDTH-1:0] + w_disp_off;
            w_disp_off    = w_disp_off + ROB_IDX_WIDTH'(rob_bus.disp_valid[i]);
        end
    end

    // Gather status of the entries at head for the retire selector.
    always_comb begin
        for (int j = 0; j < MACHINE_WIDTH; j++) begin
            w_ret_idx[j] = r_head[ROB_IDX_WIDTH-1:0] + ROB_IDX_WIDTH'(j);
            w_hv[j]      = r_rob[w_ret_idx[j]].valid;
            w_hc[j]      = r_rob[w_ret_idx[j]].complete;
            w_hm[j]      = r_rob[w_ret_idx[j]].mispredict;
            w_hh[j]      = r_rob[w_ret_idx[j]].halt;
        end
    end

    // Flag completions aimed at entries that are not live.
    always_comb begin
        for (int k = 0; k < ISSUE_WIDTH; k++) begin
            w_cdb_bad[k] = rob_bus.cdb_valid[k] && !r_rob[rob_bus.cdb_rob_entry[k]].valid;
        end
    end

    rob_retire_sel u_sel (
        .i_valid      (w_hv),
        .i_complete   (w_hc),
        .i_mispredict (w_hm),
        .i_halt       (w_hh),
        .i_halted     (r_halted),
        .o_mask       (w_ret_mask),
        .o_count      (w_ret_cnt),
        .o_nuke       (w_sel_nuke),
        .o_halt       (w_sel_halt)
    );

    rob_chk u_chk (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_cdb_bad (w_cdb_bad)
    );

    // Entry array: completion, then retire, then dispatch; a flush overrides all.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int e = 0; e < ROB_DEPTH; e++) begin
                r_rob[e] <= {$bits(ROB_ENTRY){1'b0}};
            end
        end else begin
            for (int k = 0; k < ISSUE_WIDTH; k++) begin
                if (rob_bus.cdb_valid[k] && r_rob[rob_bus.cdb_rob_entry[k]].valid) begin
                    r_rob[rob_bus.cdb_rob_entry[k]].complete   <= 1'b1;
                    r_rob[rob_bus.cdb_rob_entry[k]].mispredict <=
                        r_rob[rob_bus.cdb_rob_entry[k]].mispredict | rob_bus.cdb_mispredict[k];
                end
            end
            for (int j = 0; j < MACHINE_WIDTH; j++) begin
                if (w_ret_mask[j]) begin
                    r_rob[w_ret_idx[j]].valid    <= 1'b0;
                    r_rob[w_ret_idx[j]].complete <= 1'b0;
                end
            end
            for (int i = 0; i < MACHINE_WIDTH; i++) begin
                if (w_disp_fire && rob_bus.disp_valid[i]) begin
                    r_rob[w_disp_idx[i]] <= {1'b1, 1'b0, 1'b0, rob_bus.disp_halt[i], rob_bus.disp_arn[i],
                                             rob_bus.disp_prn[i], rob_bus.disp_old_prn[i]};
                end
            end
            if (w_sel_nuke) begin
                for (int e = 0; e < ROB_DEPTH; e++) begin
                    r_rob[e].valid    <= 1'b0;
                    r_rob[e].complete <= 1'b0;
                end
            end
        end
    end

    // Head/tail pointers; a flush collapses tail onto the post-retire head.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head <= {ROB_PTR_WIDTH{1'b0}};
            r_tail <= {ROB_PTR_WIDTH{1'b0}};
        end else begin
            r_head <= w_new_head;
            if (w_sel_nuke) begin
                r_tail <= w_new_head;
            end else if (w_disp_fire) begin
                r_tail <= r_tail + popcount_mw(rob_bus.disp_valid);
            end else begin
                r_tail <= r_tail;
            end
        end
    end

    // Registered retire packets, flush pulse and sticky halt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < MACHINE_WIDTH; j++) begin
                r_ret[j] <= {$bits(RETIRE_PACKET){1'b0}};
            end
            r_nuke   <= 1'b0;
            r_halted <= 1'b0;
        end else begin
            for (int j = 0; j < MACHINE_WIDTH; j++) begin
                r_ret[j] <= {w_ret_mask[j], r_rob[w_ret_idx[j]].arn,
                             r_rob[w_ret_idx[j]].prn, r_rob[w_ret_idx[j]].old_prn};
            end
            r_nuke   <= w_sel_nuke;
            r_halted <= r_halted | w_sel_halt;
        end
    end

    // Drive the bus outputs.
    always_comb begin
        for (int j = 0; j < MACHINE_WIDTH; j++) begin
            rob_bus.disp_entry[j]  = w_disp_idx[j];
            rob_bus.ret_valid[j]   = r_ret[j].valid;
            rob_bus.ret_arn[j]     = r_ret[j].arn;
            rob_bus.ret_prn[j]     = r_ret[j].prn;
            rob_bus.ret_old_prn[j] = r_ret[j].old_prn;
        end
        rob_bus.disp_ready   = w_disp_ready;
        rob_bus.rs_nuke      = r_nuke;
        rob_bus.rob_halted   = r_halted;
        rob_bus.rob_free_cnt = w_free;
    end

`ifdef ROB_PERF_CNT_EN
    logic [31:0] r_perf_retired;
    logic [15:0] r_perf_nuke;

    // Saturating retire and flush counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_retired <= 32'd0;
            r_perf_nuke    <= 16'd0;
        end else begin
            if (r_perf_retired > (32'hFFFF_FFFF - 32'(w_ret_cnt))) begin
                r_perf_retired <= 32'hFFFF_FFFF;
            end else begin
                r_perf_retired <= r_perf_retired + 32'(w_ret_cnt);
            end
            if (w_sel_nuke && (r_perf_nuke != 16'hFFFF)) begin
                r_perf_nuke <= r_perf_nuke + 16'd1;
            end else begin
                r_perf_nuke <= r_perf_nuke;
            end
        end
    end

    assign perf_retired = r_perf_retired;
    assign perf_nuke    = r_perf_nuke;
`endif
endmodule

// File: tb/tb_rob.sv
// Scoreboard bench for rob: dispatch pushes expected retires, a negedge monitor pops and compares.
module tb_rob;
    import rob_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    rob_if bus();
`ifdef ROB_PERF_CNT_EN
    logic [31:0] perf_retired;
    logic [15:0] perf_nuke;
`endif

    rob u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rob_bus      (bus)
`ifdef ROB_PERF_CNT_EN
        ,
        .perf_retired (perf_retired),
        .perf_nuke    (perf_nuke)
`endif
    );

    typedef struct {
        logic [ARF_WIDTH-1:0] arn;
        logic [PRF_WIDTH-1:0] prn;
        logic [PRF_WIDTH-1:0] old_prn;
        logic                 mis;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clr();
        bus.disp_valid     = '0;
        bus.disp_arn       = '0;
        bus.disp_prn       = '0;
        bus.disp_old_prn   = '0;
        bus.disp_halt      = '0;
        bus.cdb_valid      = '0;
        bus.cdb_rob_entry  = '0;
        bus.cdb_mispredict = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        clr();
    endtask

    // prn = base+i, arn = prn mod 32, old_prn = prn+64; push marks instructions expected to retire.
    task automatic disp(input logic [2:0] v, input logic [2:0] halt, input int base,
                        input logic [2:0] push, input logic [2:0] mis);
        bus.disp_valid = v;
        bus.disp_halt  = halt;
        for (int i = 0; i < MACHINE_WIDTH; i++) begin
            bus.disp_arn[i]     = ARF_WIDTH'(base + i);
            bus.disp_prn[i]     = PRF_WIDTH'(base + i);
            bus.disp_old_prn[i] = PRF_WIDTH'(base + i + 64);
            if (push[i])
                sb_q.push_back(exp_t'{arn: ARF_WIDTH'(base + i), prn: PRF_WIDTH'(base + i),
                                      old_prn: PRF_WIDTH'(base + i + 64), mis: mis[i]});
        end
    endtask

    task automatic cdb(input int port, input int entry, input logic mis);
        bus.cdb_valid[port]      = 1'b1;
        bus.cdb_rob_entry[port]  = ROB_IDX_WIDTH'(entry);
        bus.cdb_mispredict[port] = mis;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (bus.rob_free_cnt != ROB_PTR_WIDTH'(ROB_DEPTH) && n < 60) begin
            step();
            n++;
        end
        chk("drain_free_cnt", bus.rob_free_cnt, ROB_DEPTH);
        step();
        step();
    endtask

    // Monitor: every retired slot must match the scoreboard head; rs_nuke must match the popped group.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin : mon
            logic exp_nuke;
            exp_t e;
            exp_nuke = 1'b0;
            for (int j = 0; j < MACHINE_WIDTH; j++) begin
                if (bus.ret_valid[j]) begin
                    if (sb_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL ret_unexpected: slot %0d prn %0d retired, expected none", j, bus.ret_prn[j]);
                    end else begin
                        e = sb_q.pop_front();
                        exp_nuke = exp_nuke | e.mis;
                        chk("ret_prn", bus.ret_prn[j], e.prn);
                        chk("ret_arn", bus.ret_arn[j], e.arn);
                        chk("ret_old_prn", bus.ret_old_prn[j], e.old_prn);
                    end
                end
            end
            if (bus.ret_valid != 3'b000 || bus.rs_nuke)
                chk("rs_nuke", bus.rs_nuke, exp_nuke);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        clr();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_disp_ready", bus.disp_ready, 1);
        chk("rst_free_cnt", bus.rob_free_cnt, 32);
        chk("rst_ret_valid", bus.ret_valid, 0);
        chk("rst_rs_nuke", bus.rs_nuke, 0);
        chk("rst_halted", bus.rob_halted, 0);
        rst_n = 1'b1;

        // Fill: 10 groups of 3, then the ROB refuses with 2 free.
        for (int g = 0; g < 10; g++) begin
            chk("fill_disp_ready", bus.disp_ready, 1);
            disp(3'b111, 3'b000, 3 * g, 3'b111, 3'b000);
            #1;
            chk("fill_disp_entry0", bus.disp_entry[0], 3 * g);
            step();
        end
        chk("full_free_cnt", bus.rob_free_cnt, 2);
        chk("full_disp_ready", bus.disp_ready, 0);
        disp(3'b111, 3'b000, 30, 3'b000, 3'b000);
        step();
        chk("full_ignored_free_cnt", bus.rob_free_cnt, 2);
        for (int c = 0; c < 5; c++) begin
            for (int p = 0; p < ISSUE_WIDTH; p++)
                if (7 * c + p < 30) cdb(p, 7 * c + p, 1'b0);
            step();
        end
        wait_drain();

        // Wrap-around: head/tail now at 30.
        disp(3'b111, 3'b000, 40, 3'b111, 3'b000);
        #1;
        chk("wrap_entry0", bus.disp_entry[0], 30);
        chk("wrap_entry1", bus.disp_entry[1], 31);
        chk("wrap_entry2", bus.disp_entry[2], 0);
        step();
        cdb(0, 0, 1'b0);
        step();
        cdb(0, 31, 1'b0);
        step();
        cdb(0, 30, 1'b0);
        step();
        wait_drain();

        // Out-of-order completion of entries 3, 2, 1 (head at 1).
        disp(3'b111, 3'b000, 50, 3'b111, 3'b000);
        #1;
        chk("ooo_entry0", bus.disp_entry[0], 1);
        step();
        cdb(0, 3, 1'b0);
        step();
        chk("ooo_no_ret_a", bus.ret_valid, 0);
        cdb(0, 2, 1'b0);
        step();
        chk("ooo_no_ret_b", bus.ret_valid, 0);
        cdb(0, 1, 1'b0);
        step();
        chk("ooo_no_ret_c", bus.ret_valid, 0);
        step();
        chk("ooo_ret_all", bus.ret_valid, 3'b111);
        step();
        chk("ooo_free_cnt", bus.rob_free_cnt, 32);

        // Mispredict on the second of six entries (4..9).
        disp(3'b111, 3'b000, 60, 3'b011, 3'b010);
        step();
        disp(3'b111, 3'b000, 63, 3'b000, 3'b000);
        step();
        for (int p = 0; p < 6; p++) cdb(p, 4 + p, (p == 1));
        step();
        chk("mis_pre_free_cnt", bus.rob_free_cnt, 26);
        disp(3'b111, 3'b000, 70, 3'b000, 3'b000);
        #1;
        chk("mis_pre_disp_ready", bus.disp_ready, 1);
        step();
        chk("mis_nuke", bus.rs_nuke, 1);
        chk("mis_ret_valid", bus.ret_valid, 3'b011);
        chk("mis_nuke_disp_ready", bus.disp_ready, 0);
        chk("mis_free_cnt", bus.rob_free_cnt, 32);
        disp(3'b111, 3'b000, 80, 3'b000, 3'b000);
        step();
        chk("mis_nuke_low", bus.rs_nuke, 0);
        chk("mis_post_free_cnt", bus.rob_free_cnt, 32);
        chk("mis_post_disp_ready", bus.disp_ready, 1);

        // Halt in the third slot (entries 6..8), then a non-contiguous group at 9, 10.
        disp(3'b111, 3'b100, 90, 3'b111, 3'b000);
        step();
        disp(3'b101, 3'b000, 93, 3'b000, 3'b000);
        #1;
        chk("sparse_entry0", bus.disp_entry[0], 9);
        chk("sparse_entry2", bus.disp_entry[2], 10);
        step();
        for (int p = 0; p < 5; p++) cdb(p, 6 + p, 1'b0);
        step();
        chk("halt_no_ret", bus.ret_valid, 0);
        chk("halt_not_yet", bus.rob_halted, 0);
        step();
        chk("halt_ret_valid", bus.ret_valid, 3'b111);
        chk("halt_halted", bus.rob_halted, 1);
        chk("halt_disp_ready", bus.disp_ready, 0);
        repeat (4) step();
        chk("halt_stuck_ret", bus.ret_valid, 0);
        chk("halt_sticky", bus.rob_halted, 1);
        chk("halt_free_cnt", bus.rob_free_cnt, 30);

        rst_n = 1'b0;
        #1;
        chk("rst2_halted", bus.rob_halted, 0);
        chk("rst2_free_cnt", bus.rob_free_cnt, 32);
        step();
        rst_n = 1'b1;

        // Async reset in the middle of a drain.
        disp(3'b111, 3'b000, 100, 3'b111, 3'b000);
        step();
        disp(3'b111, 3'b000, 103, 3'b000, 3'b000);
        step();
        for (int p = 0; p < 6; p++) cdb(p, p, 1'b0);
        step();
        step();
        chk("areset_first_ret", bus.ret_valid, 3'b111);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("areset_ret_valid", bus.ret_valid, 0);
        chk("areset_free_cnt", bus.rob_free_cnt, 32);
        chk("areset_disp_ready", bus.disp_ready, 1);
        chk("areset_rs_nuke", bus.rs_nuke, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (5) step();
        chk("areset_post_ret", bus.ret_valid, 0);
        chk("areset_post_free", bus.rob_free_cnt, 32);

        chk("scoreboard_empty", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rob.md
# rob

Reorder buffer for the 3-way out-of-order core. Allocates in-order entries for renamed instructions at dispatch, alongside reservation-station allocation. Marks entries complete from the 7-wide CDB leaving the execute pipeline's writeback stage. Retires up to 3 instructions per cycle in program order, and raises the pipeline flush (`rs_nuke`) when a mispredicted branch retires.

## Interface
- ROB_DEPTH, 32, entries; power of two, ≥ 2×MACHINE_WIDTH
- MACHINE_WIDTH, 3, dispatch/retire slots
- ISSUE_WIDTH, 7, CDB ports
- PRF_WIDTH, 7, physical register tag bits
- ARF_WIDTH, 5, architectural register bits
- Ports:
  - clk  in  1  clock
  - rst_n  in  1  reset, asynchronous, active-low
  - disp_valid  in  MACHINE_WIDTH  dispatch slot valid
  - disp_arn / disp_prn / disp_old_prn  in  ARF_WIDTH / PRF_WIDTH / PRF_WIDTH per slot  dest arch reg, new tag, previous tag
  - disp_halt  in  MACHINE_WIDTH  slot is a halt
  - disp_ready  out  1  ROB accepts a full dispatch group this cycle
  - disp_entry  out  log2(ROB_DEPTH) per slot  entry assigned to each slot (combinational)
  - cdb_valid  in  ISSUE_WIDTH  completion valid
  - cdb_rob_entry  in  log2(ROB_DEPTH) per port  completing entry
  - cdb_mispredict  in  ISSUE_WIDTH  completing branch mispredicted
  - ret_valid  out  MACHINE_WIDTH  retired slot valid (registered)
  - ret_arn / ret_prn / ret_old_prn  out  per slot  retired mapping; old_prn returns to free list
  - rs_nuke  out  1  one-cycle flush pulse (registered)
  - rob_halted  out  1  halt retired; sticky until reset
  - rob_free_cnt  out  log2(ROB_DEPTH)+1  free entries

## Operation
- **Pointers:** head/tail are log2(ROB_DEPTH)+1 bits; the MSB is a wrap bit.
  - count = tail − head (modulo); empty when equal; full when count = ROB_DEPTH.
  - rob_free_cnt = ROB_DEPTH − count.
- **Entry fields:** valid, complete, mispredict, halt, arn, prn, old_prn.
- **Dispatch:**
  - disp_ready = (rob_free_cnt ≥ MACHINE_WIDTH) & ~rob_halted & ~rs_nuke.
  - The group is accepted whole only when disp_ready = 1; otherwise it is ignored.
  - Valid slots need not be contiguous. Slot i receives entry tail + popcount(disp_valid[i−1:0]).
  - Tail advances by popcount(disp_valid). Indices wrap modulo ROB_DEPTH.
- **Completion:**
  - Each cdb_valid[k] sets complete on entry cdb_rob_entry[k] and ORs in cdb_mispredict[k].
  - Several ports may write distinct entries in the same cycle.
  - A completion to an invalid entry is ignored; an assertion fires.
- **Retire selection (combinational, from registered state):**
  - Slot j retires if entry head+j is valid and complete, and slots 0..j−1 retire.
  - Scanning stops after the first retiring entry with mispredict or halt; that entry itself retires.
  - Nothing retires while rob_halted = 1.
- **Retire update:** at the edge, head advances by the retire count, retired entries are invalidated, and ret_* are loaded.
- **Flush on mispredict:** if a retiring entry has mispredict, at the same edge:
  - tail is set equal to the new head;
  - all valid and complete bits are cleared;
  - any dispatch presented that cycle is dropped;
  - rs_nuke = 1 for the next cycle.
- **Halt:** a retiring halt sets rob_halted at the edge.
- **Reset values:** all outputs 0 except disp_ready = 1 and rob_free_cnt = ROB_DEPTH; head = tail = 0; all entries invalid.
- **Reset mid-operation:** discards all state immediately.

## Timing
- disp_entry is valid in the same cycle as disp_valid; the entry is written at that cycle's edge.
- An entry dispatched at edge t can be completed by a CDB write in cycle t+1 at the earliest.
- CDB write in cycle c:
  - complete bit set at the end of c;
  - retire decided at the end of c+1;
  - ret_valid high during c+2.
- A completion and a retire decision in the same cycle for the same entry do not retire it; it retires the following cycle.
- Dispatch and retire in the same cycle are both applied. The free count uses pre-retire state, so freed entries are usable next cycle.
- rs_nuke is high exactly one cycle, coincident with the ret_valid of the mispredicted branch. disp_ready is 0 during that cycle.

## Configuration
- ROB_PERF_CNT_EN defined:
  - adds output perf_retired (32 bits, total instructions retired);
  - adds output perf_nuke (16 bits, flush count);
  - both saturate and reset to 0.
- ROB_PERF_CNT_EN undefined: these ports and counters do not exist; behaviour is otherwise identical.

## Structure
- Shared package:
  - ROB_ENTRY struct;
  - ROB_DEPTH and ROB_IDX_WIDTH constants;
  - RETIRE_PACKET struct (valid, arn, prn, old_prn), used by the rename free list and the arch map.
- Sub-module `rob_retire_sel`: combinational. Takes the MACHINE_WIDTH entries at head and outputs the per-slot retire mask, retire count and nuke flag.

## Test plan
- **Fill and drain:** dispatch 3/cycle to an empty ROB.
  - disp_ready drops when rob_free_cnt reaches 2 (after 30 dispatched with ROB_DEPTH = 32).
  - Completing all entries drains 3/cycle, in order, 2 cycles after completion.
- **Out-of-order completion:** complete entries 2, 1, 0 in separate cycles.
  - No retire until entry 0 completes.
  - Then ret_valid = 3'b111 in the same cycle, with prns in program order.
- **Mispredict:** entries 0–5 dispatched, entry 1 completes with mispredict, entries 0–5 complete.
  - Retire 0 and 1 only; rs_nuke pulses once.
  - rob_free_cnt returns to 32; a dispatch in the nuke cycle is dropped.
- **Wrap-around:** advance head/tail to 30, then dispatch 3.
  - disp_entry = 30, 31, 0; retirement order is preserved across the wrap.
- **Halt:** a halt at entry 2 with entries 0–4 complete.
  - Retire 0–2; rob_halted = 1.
  - Entries 3–4 are never retired; disp_ready = 0.
- **Async reset:** assert rst_n mid-drain.
  - Outputs return to their reset values immediately; nothing retires after release.
